// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 5-stage MIPS pipeline.
// Owns the PC, presents it to instruction memory combinationally, captures the
// returned word into the IF/ID register and arbitrates every PC redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
    parameter logic [31:0] IRQ_VECTOR   = 32'h8000_0004,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0008,
    parameter logic [31:0] NOP          = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        exception_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_en_i,
    input  logic [31:0] jump_target_i,
    input  logic        irq_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc_plus4_o,
    output logic        ifid_valid_o,
    output logic        irq_taken_o,
    output logic [31:0] epc_o,
    output logic        kernel_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic [31:0] pc_plus4;
    logic        irq_ok;
    logic        redirect;

    // Sequential successor; carry out of bit 31 is dropped so the PC wraps.
    assign pc_plus4 = pc_q + 32'd4;

    // Interrupts are only accepted in user mode and only when nothing else is
    // steering the PC; the request is a level and is not remembered.
    assign irq_ok = irq_i & ~pc_q[31] & ~exception_i & ~branch_taken_i
                    & ~jump_en_i & ~stall_i;

    // Any redirect both moves the PC and kills the word fetched this cycle
    // (there is no delay slot).
    assign redirect = exception_i | branch_taken_i | jump_en_i | irq_ok;

    // Next-PC selection: redirects in fixed priority, and they win over stall.
    always_comb begin
        pc_d = pc_plus4;
        if (exception_i) begin
            pc_d = EXC_VECTOR;
        end else if (branch_taken_i) begin
            pc_d = branch_target_i;
        end else if (jump_en_i) begin
            pc_d = jump_target_i;
        end else if (irq_ok) begin
            pc_d = IRQ_VECTOR;
        end else if (stall_i) begin
            pc_d = pc_q;
        end
    end

    // IF/ID next state: squash on redirect or flush, hold on stall, else capture.
    always_comb begin
        ifid_instr_d    = imem_data_i;
        ifid_pc_plus4_d = pc_plus4;
        ifid_valid_d    = 1'b1;
        if (redirect || flush_i) begin
            ifid_instr_d    = NOP;
            ifid_pc_plus4_d = 32'd0;
            ifid_valid_d    = 1'b0;
        end else if (stall_i) begin
            ifid_instr_d    = ifid_instr_q;
            ifid_pc_plus4_d = ifid_pc_plus4_q;
            ifid_valid_d    = ifid_valid_q;
        end
    end

    // PC and IF/ID registers; reset drops any in-flight redirect.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pc_q            <= RESET_VECTOR;
            ifid_instr_q    <= NOP;
            ifid_pc_plus4_q <= 32'd0;
            ifid_valid_q    <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            ifid_instr_q    <= ifid_instr_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
            ifid_valid_q    <= ifid_valid_d;
        end
    end

    assign imem_addr_o     = pc_q;
    assign epc_o           = pc_q;
    assign kernel_o        = pc_q[31];
    assign irq_taken_o     = irq_ok & ~reset_i;
    assign ifid_instr_o    = ifid_instr_q;
    assign ifid_pc_plus4_o = ifid_pc_plus4_q;
    assign ifid_valid_o    = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors with hand-computed expectations for fetch_stage.
module tb_fetch_stage;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        stall_i;
    logic        flush_i;
    logic        exception_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        jump_en_i;
    logic [31:0] jump_target_i;
    logic        irq_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc_plus4_o;
    logic        ifid_valid_o;
    logic        irq_taken_o;
    logic [31:0] epc_o;
    logic        kernel_o;

    int total_cnt = 0;
    int bad_cnt   = 0;

    fetch_stage dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .exception_i     (exception_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_en_i       (jump_en_i),
        .jump_target_i   (jump_target_i),
        .irq_i           (irq_i),
        .imem_addr_o     (imem_addr_o),
        .imem_data_i     (imem_data_i),
        .ifid_instr_o    (ifid_instr_o),
        .ifid_pc_plus4_o (ifid_pc_plus4_o),
        .ifid_valid_o    (ifid_valid_o),
        .irq_taken_o     (irq_taken_o),
        .epc_o           (epc_o),
        .kernel_o        (kernel_o)
    );

    always #5 clk_i = ~clk_i;

    // Single comparison point: counts and reports every check.
    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total_cnt++;
        if (obs !== exp_v) begin
            bad_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp_v);
        end else begin
            $display("ok   %s: %08h", tag, obs);
        end
    endtask

    // Advance one clock and land 1 time unit past the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid);
        chk_val({tag, ".instr"}, ifid_instr_o, instr);
        chk_val({tag, ".pc4"},   ifid_pc_plus4_o, pc4);
        chk_val({tag, ".valid"}, {31'd0, ifid_valid_o}, {31'd0, valid});
    endtask

    task automatic clear_ev();
        stall_i        = 1'b0;
        flush_i        = 1'b0;
        exception_i    = 1'b0;
        branch_taken_i = 1'b0;
        jump_en_i      = 1'b0;
        irq_i          = 1'b0;
    endtask

    // One-cycle jump to place the PC at a chosen address.
    task automatic jump_to(input logic [31:0] tgt);
        clear_ev();
        jump_en_i     = 1'b1;
        jump_target_i = tgt;
        step();
        jump_en_i = 1'b0;
    endtask

    initial begin
        reset_i         = 1'b1;
        branch_target_i = 32'd0;
        jump_target_i   = 32'd0;
        imem_data_i     = 32'd0;
        clear_ev();
        irq_i = 1'b1;
        #3;
        // 1: reset state
        chk_val("rst.pc", imem_addr_o, 32'h8000_0000);
        chk_ifid("rst", 32'h0, 32'h0, 1'b0);
        chk_val("rst.irq_taken", {31'd0, irq_taken_o}, 32'd0);
        chk_val("rst.kernel", {31'd0, kernel_o}, 32'd1);
        step();
        step();
        reset_i = 1'b0;
        irq_i   = 1'b0;

        // 1: sequential fetch A, B, C
        imem_data_i = 32'hAAAA_0001;
        #1 chk_val("seq.addr0", imem_addr_o, 32'h8000_0000);
        step();
        chk_val("seq.addr1", imem_addr_o, 32'h8000_0004);
        chk_ifid("seq.A", 32'hAAAA_0001, 32'h8000_0004, 1'b1);
        imem_data_i = 32'hBBBB_0002;
        step();
        chk_val("seq.addr2", imem_addr_o, 32'h8000_0008);
        chk_ifid("seq.B", 32'hBBBB_0002, 32'h8000_0008, 1'b1);
        imem_data_i = 32'hCCCC_0003;
        step();
        chk_val("seq.addr3", imem_addr_o, 32'h8000_000C);
        chk_ifid("seq.C", 32'hCCCC_0003, 32'h8000_000C, 1'b1);

        // 2: reach pc=0000_0010 with a real instruction in IF/ID, then stall
        jump_to(32'h0000_000C);
        chk_val("jmp.addr", imem_addr_o, 32'h0000_000C);
        chk_val("jmp.kernel", {31'd0, kernel_o}, 32'd0);
        chk_ifid("jmp", 32'h0, 32'h0, 1'b0);
        imem_data_i = 32'hEEEE_0005;
        step();
        chk_val("pre.addr", imem_addr_o, 32'h0000_0010);
        stall_i     = 1'b1;
        imem_data_i = 32'hFFFF_0006;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_val("stall.addr", imem_addr_o, 32'h0000_0010);
            chk_ifid("stall", 32'hEEEE_0005, 32'h0000_0010, 1'b1);
        end
        stall_i = 1'b0;
        step();
        chk_val("unstall.addr", imem_addr_o, 32'h0000_0014);
        chk_ifid("unstall", 32'hFFFF_0006, 32'h0000_0014, 1'b1);

        // 2b: flush squashes IF/ID but PC still advances
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk_val("flush.addr", imem_addr_o, 32'h0000_0018);
        chk_ifid("flush", 32'h0, 32'h0, 1'b0);

        // 3: branch overrides stall
        stall_i         = 1'b1;
        branch_taken_i  = 1'b1;
        branch_target_i = 32'h0000_0040;
        step();
        clear_ev();
        chk_val("br.addr", imem_addr_o, 32'h0000_0040);
        chk_ifid("br", 32'h0, 32'h0, 1'b0);

        // 4: interrupt in user mode
        jump_to(32'h0000_0020);
        irq_i = 1'b1;
        #1;
        chk_val("irq.taken", {31'd0, irq_taken_o}, 32'd1);
        chk_val("irq.epc", epc_o, 32'h0000_0020);
        step();
        chk_val("irq.addr", imem_addr_o, 32'h8000_0004);
        chk_ifid("irq", 32'h0, 32'h0, 1'b0);
        // 4b: kernel mode ignores irq
        jump_to(32'h8000_0010);
        irq_i       = 1'b1;
        imem_data_i = 32'h1234_5678;
        #1;
        chk_val("kirq.taken", {31'd0, irq_taken_o}, 32'd0);
        step();
        chk_val("kirq.addr", imem_addr_o, 32'h8000_0014);
        chk_ifid("kirq", 32'h1234_5678, 32'h8000_0014, 1'b1);

        // 5: everything at once from user mode -> exception wins
        jump_to(32'h0000_0030);
        exception_i     = 1'b1;
        branch_taken_i  = 1'b1;
        branch_target_i = 32'h0000_0100;
        jump_en_i       = 1'b1;
        jump_target_i   = 32'h0000_0200;
        irq_i           = 1'b1;
        #1;
        chk_val("all.taken", {31'd0, irq_taken_o}, 32'd0);
        step();
        clear_ev();
        chk_val("all.addr", imem_addr_o, 32'h8000_0008);
        chk_ifid("all", 32'h0, 32'h0, 1'b0);

        // 5b: branch beats jump
        branch_taken_i  = 1'b1;
        branch_target_i = 32'h0000_0100;
        jump_en_i       = 1'b1;
        jump_target_i   = 32'h0000_0200;
        step();
        clear_ev();
        chk_val("bj.addr", imem_addr_o, 32'h0000_0100);

        // 6: PC wrap, then reset in the middle of a stall
        jump_to(32'hFFFF_FFFC);
        imem_data_i = 32'h9999_0007;
        step();
        chk_val("wrap.addr", imem_addr_o, 32'h0000_0000);
        chk_ifid("wrap", 32'h9999_0007, 32'h0000_0000, 1'b1);
        stall_i = 1'b1;
        step();
        chk_val("pre_rst.addr", imem_addr_o, 32'h0000_0000);
        #2 reset_i = 1'b1;
        #1;
        chk_val("mrst.addr", imem_addr_o, 32'h8000_0000);
        chk_val("mrst.valid", {31'd0, ifid_valid_o}, 32'd0);
        step();
        reset_i = 1'b0;
        clear_ev();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
